// File: rtl/i2s_clkws_detect.sv
// Receive-side I2S clock/WS detector: synchronizes external SCK/WS, measures the SCK period,
// tracks bit/word position and verifies the WS frame length before reporting lock.
module i2s_clkws_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic                pad_sck_i,
  input  logic                pad_ws_i,
  input  logic [4:0]          cfg_word_size_i,
  input  logic [3:0]          cfg_word_num_i,
  input  logic                cfg_dsp_en_i,
  input  logic                err_clr_i,
  output logic                sck_rise_o,
  output logic                sck_fall_o,
  output logic                ws_edge_o,
  output logic                frame_start_o,
  output logic [4:0]          bit_cnt_o,
  output logic [3:0]          word_cnt_o,
  output logic [PERIOD_W-1:0] sck_period_o,
  output logic                locked_o,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, CHECK, LOCKED} state_t;

  localparam logic [PERIOD_W-1:0] PER_MAX  = '1;
  localparam logic [9:0]          INTV_MAX = 10'd1023;
  localparam logic [3:0]          LOCK_N   = 4'(LOCK_FRAMES);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic                   sck_dly;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   ws_smp;
  logic                   ws_prev;
  logic                   ws_qual;
  logic [4:0]             bit_cnt;
  logic [3:0]             word_cnt;
  logic [9:0]             interval;
  logic [9:0]             expected;
  logic                   frame_good;
  logic [PERIOD_W-1:0]    per_cnt;
  logic [PERIOD_W-1:0]    sck_period;
  logic                   timeout;
  state_t                 state;
  state_t                 state_next;
  logic [3:0]             good_cnt;
  logic [3:0]             good_next;
  logic                   err;
  logic                   err_next;

  wire sck_s = sck_sync[SYNC_STAGES-1];

  // Synchronizers keep tracking while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_dly  <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      ws_smp   <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], pad_sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], pad_ws_i};
      sck_dly  <= sck_s;
      sck_rise <= en_i & sck_s & ~sck_dly;
      sck_fall <= en_i & ~sck_s & sck_dly;
      ws_smp   <= ws_sync[SYNC_STAGES-1];
    end
  end

  assign ws_qual = sck_rise & (cfg_dsp_en_i ? (ws_smp & ~ws_prev) : (ws_smp ^ ws_prev));

  assign expected   = ({5'd0, cfg_word_size_i} + 10'd1) * ({6'd0, cfg_word_num_i} + 10'd1);
  assign frame_good = (interval == expected);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ws_prev  <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      interval <= '0;
    end else if (!en_i) begin
      ws_prev  <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      interval <= '0;
    end else if (sck_rise) begin
      ws_prev <= ws_smp;
      if (ws_qual) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        interval <= 10'd1;
      end else begin
        if (bit_cnt >= cfg_word_size_i) begin
          bit_cnt  <= '0;
          word_cnt <= (word_cnt >= cfg_word_num_i) ? 4'd0 : word_cnt + 4'd1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (interval != INTV_MAX)
          interval <= interval + 10'd1;
      end
    end
  end

  // Period counter saturation doubles as the SCK-loss timeout.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      per_cnt    <= '0;
      sck_period <= '0;
    end else if (!en_i) begin
      per_cnt    <= '0;
      sck_period <= '0;
    end else if (sck_rise) begin
      per_cnt    <= '0;
      sck_period <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;
    end else if (per_cnt != PER_MAX) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  assign timeout = en_i & ~sck_rise & (per_cnt == PER_MAX);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      good_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    err_next   = err & ~err_clr_i;
    if (!en_i) begin
      state_next = IDLE;
      good_next  = '0;
    end else begin
      case (state)
        IDLE: state_next = SEARCH;
        SEARCH: begin
          if (ws_qual) begin
            state_next = CHECK;
            good_next  = '0;
          end
        end
        CHECK: begin
          if (timeout) begin
            state_next = SEARCH;
          end else if (ws_qual) begin
            if (!frame_good) begin
              good_next = '0;
            end else if (good_cnt + 4'd1 >= LOCK_N) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              good_next = good_cnt + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_next = SEARCH;
          end else if (ws_qual && !frame_good) begin
            state_next = CHECK;
            good_next  = '0;
            err_next   = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign sck_rise_o    = sck_rise;
  assign sck_fall_o    = sck_fall;
  assign ws_edge_o     = ws_qual;
  assign locked_o      = (state == LOCKED);
  assign frame_start_o = ws_qual & locked_o & (cfg_dsp_en_i | ~ws_smp);
  assign bit_cnt_o     = bit_cnt;
  assign word_cnt_o    = word_cnt;
  assign sck_period_o  = sck_period;
  assign err_o         = err;

endmodule

// File: tb/tb_i2s_clkws_detect.sv
// Directed bench for i2s_clkws_detect: drives SCK/WS pads at 8 clk per bit and checks
// pulses, counters, period, lock and error behaviour against hand-computed values.
module tb_i2s_clkws_detect;

  localparam int PW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          en_i = 1'b0;
  logic          pad_sck_i = 1'b0;
  logic          pad_ws_i = 1'b0;
  logic [4:0]    cfg_word_size_i = 5'd15;
  logic [3:0]    cfg_word_num_i = 4'd0;
  logic          cfg_dsp_en_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic          sck_rise_o;
  logic          sck_fall_o;
  logic          ws_edge_o;
  logic          frame_start_o;
  logic [4:0]    bit_cnt_o;
  logic [3:0]    word_cnt_o;
  logic [PW-1:0] sck_period_o;
  logic          locked_o;
  logic          err_o;

  i2s_clkws_detect #(.SYNC_STAGES(2), .PERIOD_W(PW), .LOCK_FRAMES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i),
    .pad_sck_i(pad_sck_i), .pad_ws_i(pad_ws_i),
    .cfg_word_size_i(cfg_word_size_i), .cfg_word_num_i(cfg_word_num_i),
    .cfg_dsp_en_i(cfg_dsp_en_i), .err_clr_i(err_clr_i),
    .sck_rise_o(sck_rise_o), .sck_fall_o(sck_fall_o), .ws_edge_o(ws_edge_o),
    .frame_start_o(frame_start_o), .bit_cnt_o(bit_cnt_o), .word_cnt_o(word_cnt_o),
    .sck_period_o(sck_period_o), .locked_o(locked_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_rise, n_fall, n_edge, n_fs;
  int   last_bit, last_word;
  int   clr_arm = 0;
  logic prev_rise = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic reset_counts();
    n_rise = 0; n_fall = 0; n_edge = 0; n_fs = 0;
  endtask

  // Called #1 after every posedge while pads are driven.
  task automatic sample();
    if (clr_arm == 2) begin
      err_clr_i = 1'b0;
      clr_arm = 0;
    end
    if (prev_rise) begin
      last_bit  = int'(bit_cnt_o);
      last_word = int'(word_cnt_o);
    end
    prev_rise = sck_rise_o;
    if (sck_rise_o) n_rise++;
    if (sck_fall_o) n_fall++;
    if (ws_edge_o) n_edge++;
    if (frame_start_o) n_fs++;
    if (sck_rise_o && clr_arm == 1) begin
      err_clr_i = 1'b1;
      clr_arm = 2;
    end
  endtask

  task automatic sck_bit(input logic ws);
    pad_ws_i = ws;
    pad_sck_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; sample(); end
    pad_sck_i = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; sample(); end
  endtask

  task automatic send(input logic ws, input int n);
    repeat (n) sck_bit(ws);
  endtask

  task automatic dsp_frame(input int n);
    sck_bit(1'b1);
    send(1'b0, n - 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_counts();
    last_bit = 0;
    last_word = 0;
    tick(3);
    rstn_i = 1'b1;

    // 1: disabled, pads toggling
    send(1'b1, 2);
    send(1'b0, 2);
    check("t1_rise", n_rise, 0);
    check("t1_fall", n_fall, 0);
    check("t1_ws_edge", n_edge, 0);
    check("t1_bit_cnt", int'(bit_cnt_o), 0);
    check("t1_period", int'(sck_period_o), 0);
    check("t1_locked", int'(locked_o), 0);
    check("t1_err", int'(err_o), 0);

    // 2: I2S W=15 N=0
    en_i = 1'b1;
    tick(2);
    reset_counts();
    send(1'b0, 16);
    check("t2_period", int'(sck_period_o), 8);
    check("t2_rise_cnt", n_rise, 16);
    check("t2_fall_cnt", n_fall, 16);
    check("t2_no_edge", n_edge, 0);
    send(1'b1, 16);
    check("t2_locked_e1", int'(locked_o), 0);
    send(1'b0, 16);
    check("t2_locked_e2", int'(locked_o), 0);
    reset_counts();
    send(1'b1, 16);
    check("t2_locked_e3", int'(locked_o), 1);
    check("t2_fs_rise", n_fs, 0);
    check("t2_bit_last", last_bit, 15);
    check("t2_word_last", last_word, 0);
    reset_counts();
    send(1'b0, 16);
    check("t2_fs_fall", n_fs, 1);
    check("t2_edge_fall", n_edge, 1);
    reset_counts();
    send(1'b1, 16);
    check("t2_fs_rise2", n_fs, 0);
    check("t2_edge_rise2", n_edge, 1);

    // 3: short interval while locked
    send(1'b0, 15);
    send(1'b1, 16);
    check("t3_err_set", int'(err_o), 1);
    check("t3_unlock", int'(locked_o), 0);
    send(1'b0, 16);
    check("t3_relock_1", int'(locked_o), 0);
    send(1'b1, 16);
    check("t3_relock_2", int'(locked_o), 1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("t3_err_clr", int'(err_o), 0);
    send(1'b0, 15);
    clr_arm = 1;
    sck_bit(1'b1);
    check("t3_set_wins", int'(err_o), 1);
    check("t3_unlock2", int'(locked_o), 0);
    send(1'b1, 15);

    // 4: DSP W=7 N=3
    en_i = 1'b0;
    tick(2);
    cfg_dsp_en_i = 1'b1;
    cfg_word_size_i = 5'd7;
    cfg_word_num_i = 4'd3;
    en_i = 1'b1;
    tick(2);
    dsp_frame(32);
    dsp_frame(32);
    check("t4_locked_f2", int'(locked_o), 0);
    reset_counts();
    dsp_frame(32);
    check("t4_locked_f3", int'(locked_o), 1);
    check("t4_fs_lockedge", n_fs, 0);
    check("t4_edges_f3", n_edge, 1);
    check("t4_bit_end", last_bit, 7);
    check("t4_word_end", last_word, 3);
    reset_counts();
    dsp_frame(10);
    check("t4_fs", n_fs, 1);
    check("t4_bit_mid", last_bit, 1);
    check("t4_word_mid", last_word, 1);
    send(1'b0, 22);
    check("t4_edges_f4", n_edge, 1);
    check("t4_err_kept", int'(err_o), 1);

    // 5: SCK stops while locked
    pad_sck_i = 1'b0;
    tick(240);
    check("t5_locked_before", int'(locked_o), 1);
    tick(30);
    check("t5_unlock", int'(locked_o), 0);
    check("t5_err_kept", int'(err_o), 1);
    dsp_frame(32);
    dsp_frame(32);
    check("t5_search_f2", int'(locked_o), 0);
    dsp_frame(32);
    check("t5_relock", int'(locked_o), 1);

    // 6: disable mid-word, then async reset mid-frame
    dsp_frame(13);
    check("t6_bit_mid", last_bit, 4);
    en_i = 1'b0;
    tick(2);
    check("t6_bit_clr", int'(bit_cnt_o), 0);
    check("t6_word_clr", int'(word_cnt_o), 0);
    check("t6_period_clr", int'(sck_period_o), 0);
    check("t6_locked_clr", int'(locked_o), 0);
    check("t6_err_kept", int'(err_o), 1);
    en_i = 1'b1;
    tick(2);
    dsp_frame(20);
    check("t6_word_pre_rst", last_word, 2);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_rst_bit", int'(bit_cnt_o), 0);
    check("t6_rst_word", int'(word_cnt_o), 0);
    check("t6_rst_err", int'(err_o), 0);
    check("t6_rst_period", int'(sck_period_o), 0);
    tick(2);
    rstn_i = 1'b1;
    tick(2);
    reset_counts();
    dsp_frame(32);
    dsp_frame(32);
    check("t6_locked_f2", int'(locked_o), 0);
    dsp_frame(32);
    check("t6_relock", int'(locked_o), 1);
    check("t6_edges", n_edge, 3);
    check("t6_err_after", int'(err_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
